reg16_serial_tx: RTL and testbench



---
 rtl/reg16_serial_tx.sv | 163 ++++++++++++++++
 tb/tb_reg16_serial_tx.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg16_serial_tx.sv
// reg16_serial_tx: parallel-to-serial transmitter.
// Accepts a DATA_W-bit word on a valid/ready handshake and shifts it out
// MSB-first on ser_out. Each bit is held CLKS_PER_BIT cycles, and ser_frame
// is high while a bit of the frame is on the line. done pulses for one cycle
// after the final bit.
// Optional build macro TX_PARITY_EN: appends one even-parity bit (XOR of the
// data bits) to each frame. Without the macro no parity logic exists.
module reg16_serial_tx #(
  parameter int DATA_W       = 16,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ser_out,
  output logic              ser_frame,
  output logic              done
);

  // Number of serial bits in one frame (data bits, plus parity when enabled).
`ifdef TX_PARITY_EN
  localparam int NBITS = DATA_W + 1;
`else
  localparam int NBITS = DATA_W;
`endif

  // The bit counter must reach NBITS-1; the cycle counter must reach
  // CLKS_PER_BIT-1. Neither ever counts past its terminal value.
  localparam int BIT_W = $clog2(NBITS);
  localparam int CYC_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(NBITS - 1);
  localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'(CLKS_PER_BIT - 1);
`ifdef TX_PARITY_EN
  localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_W - 1);
`endif

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t state_q, state_d;

  // The MSB goes straight to ser_out on the accept edge, so the shift register
  // only needs to keep the remaining DATA_W-1 bits, next bit in its top position.
  logic [DATA_W-2:0] shift_q, shift_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [CYC_W-1:0]  cyc_cnt_q, cyc_cnt_d;
  logic              ser_out_q, ser_out_d;
  logic              ser_frame_q, ser_frame_d;
  logic              in_ready_q, in_ready_d;
  logic              done_q, done_d;
`ifdef TX_PARITY_EN
  logic              parity_q, parity_d;
`endif

  // Next-state and next-output logic for the IDLE/SHIFT sequencer.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    cyc_cnt_d   = cyc_cnt_q;
    ser_out_d   = ser_out_q;
    ser_frame_d = ser_frame_q;
    in_ready_d  = in_ready_q;
    done_d      = 1'b0;
`ifdef TX_PARITY_EN
    parity_d    = parity_q;
`endif

    unique case (state_q)
      IDLE: begin
        // Line is quiet while idle; a word is taken only when we advertise ready.
        ser_out_d   = 1'b0;
        ser_frame_d = 1'b0;
        in_ready_d  = 1'b1;
        if (in_valid && in_ready_q) begin
          shift_d     = in_data[DATA_W-2:0];
          ser_out_d   = in_data[DATA_W-1];
          ser_frame_d = 1'b1;
          in_ready_d  = 1'b0;
          bit_cnt_d   = '0;
          cyc_cnt_d   = '0;
`ifdef TX_PARITY_EN
          parity_d    = ^in_data;
`endif
          state_d     = SHIFT;
        end
      end

      SHIFT: begin
        if (cyc_cnt_q == CYC_LAST) begin
          cyc_cnt_d = '0;
          if (bit_cnt_q == LAST_BIT) begin
            // Final bit has been held long enough: close the frame. The done
            // cycle doubles as the mandatory idle gap before the next frame.
            ser_out_d   = 1'b0;
            ser_frame_d = 1'b0;
            done_d      = 1'b1;
            in_ready_d  = 1'b1;
            bit_cnt_d   = '0;
            state_d     = IDLE;
`ifdef TX_PARITY_EN
          end else if (bit_cnt_q == LAST_DATA) begin
            // Data bits exhausted: the parity bit occupies one more bit slot.
            ser_out_d = parity_q;
            bit_cnt_d = bit_cnt_q + 1'b1;
`endif
          end else begin
            ser_out_d = shift_q[DATA_W-2];
            shift_d   = shift_q << 1;
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else begin
          cyc_cnt_d = cyc_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; a low rst_n at the edge wins over everything,
  // aborting any frame in flight without a done pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      cyc_cnt_q   <= '0;
      ser_out_q   <= 1'b0;
      ser_frame_q <= 1'b0;
      in_ready_q  <= 1'b1;
      done_q      <= 1'b0;
`ifdef TX_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      cyc_cnt_q   <= cyc_cnt_d;
      ser_out_q   <= ser_out_d;
      ser_frame_q <= ser_frame_d;
      in_ready_q  <= in_ready_d;
      done_q      <= done_d;
`ifdef TX_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign ser_out   = ser_out_q;
  assign ser_frame = ser_frame_q;
  assign done      = done_q;

endmodule

// File: tb/tb_reg16_serial_tx.sv
// Bench for reg16_serial_tx: instance 0 runs at 1 clock per bit, instance 1
// at 3 clocks per bit. Accepted words go into a per-instance queue; a monitor
// rebuilds each frame from the line and checks it against the popped word.
module tb_reg16_serial_tx;

`ifdef TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] in_data [2];
  logic        in_valid [2];
  logic        in_ready [2];
  logic        ser_out [2];
  logic        ser_frame [2];
  logic        done [2];

  int total = 0;
  int bad   = 0;

  logic [15:0] q0[$];
  logic [15:0] q1[$];
  int          accepted [2];
  int          frames [2];
  int          last_gap [2];

  always #5 clk = ~clk;

  reg16_serial_tx #(.DATA_W(16), .CLKS_PER_BIT(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .ser_out(ser_out[0]), .ser_frame(ser_frame[0]),
    .done(done[0])
  );

  reg16_serial_tx #(.DATA_W(16), .CLKS_PER_BIT(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .ser_out(ser_out[1]), .ser_frame(ser_frame[1]),
    .done(done[1])
  );

  function automatic int cpb_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  // Line pattern expected for one frame: every bit repeated cpb times, MSB first.
  function automatic logic [63:0] exp_line(input logic [15:0] w, input int cpb);
    logic [63:0] r;
    r = '0;
    for (int b = 15; b >= 0; b--)
      for (int k = 0; k < cpb; k++) r = {r[62:0], w[b]};
    if (PAR == 1)
      for (int k = 0; k < cpb; k++) r = {r[62:0], ^w};
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int qsize(input int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  // Frame monitor: samples on the falling edge, away from the active edge.
  initial begin : monitor
    logic [63:0] got [2];
    int          got_len [2];
    int          gap [2];
    logic [15:0] w;
    for (int i = 0; i < 2; i++) begin
      got[i] = '0; got_len[i] = 0; gap[i] = 0; frames[i] = 0; last_gap[i] = -1;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!rst_n) begin
          got[i] = '0; got_len[i] = 0; gap[i] = 0; last_gap[i] = -1;
        end else if (ser_frame[i] === 1'b1) begin
          if (got_len[i] == 0 && last_gap[i] != -2 && frames[i] > 0) begin
            last_gap[i] = gap[i];
            chk("gap_min", 64'(gap[i] >= 1), 64'd1);
          end
          gap[i] = 0;
          got[i] = {got[i][62:0], ser_out[i]};
          got_len[i]++;
          chk("ready_low_in_frame", 64'(in_ready[i]), 64'd0);
          chk("no_done_in_frame", 64'(done[i]), 64'd0);
        end else begin
          gap[i]++;
          if (done[i] === 1'b1) begin
            frames[i]++;
            chk("ready_with_done", 64'(in_ready[i]), 64'd1);
            chk("done_has_frame", 64'(qsize(i) > 0), 64'd1);
            if (qsize(i) > 0) begin
              w = (i == 0) ? q0.pop_front() : q1.pop_front();
              chk($sformatf("frame_bits_%0d_%h", i, w), got[i], exp_line(w, cpb_of(i)));
              chk($sformatf("frame_len_%0d_%h", i, w), 64'(got_len[i]),
                  64'((16 + PAR) * cpb_of(i)));
            end
            got[i] = '0;
            got_len[i] = 0;
          end
        end
      end
    end
  end

  // Offer a word and wait (bounded) for the accept edge; optionally keep valid high.
  task automatic send(input int i, input logic [15:0] w, input bit hold);
    bit ok;
    ok = 1'b0;
    in_data[i]  = w;
    in_valid[i] = 1'b1;
    for (int k = 0; k < 300; k++) begin
      if (in_ready[i] === 1'b1) begin
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk($sformatf("accept_%0d_%h", i, w), 64'(ok), 64'd1);
    if (ok) begin
      if (i == 0) q0.push_back(w); else q1.push_back(w);
      accepted[i]++;
      chk("first_bit_frame", 64'(ser_frame[i]), 64'd1);
      chk("first_bit_msb", 64'(ser_out[i]), 64'(w[15]));
    end
    if (!hold) in_valid[i] = 1'b0;
  endtask

  // Wait (bounded) until all queued frames of instance i have completed.
  task automatic wait_idle(input int i);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (qsize(i) == 0 && ser_frame[i] === 1'b0) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk($sformatf("idle_timeout_%0d", i), 64'(ok), 64'd1);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    for (int i = 0; i < 2; i++) begin
      in_data[i] = '0; in_valid[i] = 1'b0; accepted[i] = 0;
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_ready", 64'(in_ready[i]), 64'd1);
      chk("rst_ser_out", 64'(ser_out[i]), 64'd0);
      chk("rst_frame", 64'(ser_frame[i]), 64'd0);
      chk("rst_done", 64'(done[i]), 64'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single word at one clock per bit.
    send(0, 16'hA5C3, 1'b0);
    wait_idle(0);

    // Valid held high across two words: back-to-back frames, one idle cycle apart.
    send(0, 16'h0001, 1'b1);
    send(0, 16'h8000, 1'b0);
    wait_idle(0);
    chk("b2b_gap", 64'(last_gap[0]), 64'd1);

    // A valid pulse while busy must be dropped.
    send(0, 16'h0000, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    in_data[0] = 16'hFFFF; in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    chk("ignored_ready", 64'(in_ready[0]), 64'd0);
    wait_idle(0);
    repeat (25) @(posedge clk);
    #1;
    chk("no_second_frame", 64'(frames[0]), 64'(accepted[0]));

    // Three clocks per bit.
    send(1, 16'h8001, 1'b0);
    wait_idle(1);

    // Reset in the middle of a frame, then a clean frame afterwards.
    send(0, 16'h1234, 1'b0);
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    void'(q0.pop_front());
    accepted[0]--;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort_frame", 64'(ser_frame[0]), 64'd0);
    chk("abort_ser_out", 64'(ser_out[0]), 64'd0);
    chk("abort_ready", 64'(in_ready[0]), 64'd1);
    chk("abort_done", 64'(done[0]), 64'd0);
    repeat (20) @(posedge clk);
    #1;
    chk("abort_no_done", 64'(frames[0]), 64'(accepted[0]));
    send(0, 16'h00FF, 1'b0);
    wait_idle(0);

    // Parity-relevant words (plain frames when parity is not built in).
    send(0, 16'h0007, 1'b0);
    send(0, 16'h0003, 1'b0);
    wait_idle(0);
    send(1, 16'h0007, 1'b0);
    wait_idle(1);

    repeat (5) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("frame_count_%0d", i), 64'(frames[i]), 64'(accepted[i]));
      chk($sformatf("queue_empty_%0d", i), 64'(qsize(i)), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
